// File: rtl/posit_host_driver.sv
// posit_host_driver: streams two posit32 operands bytewise into the multiplier wrapper and reads back the product
module posit_host_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_product,
  output logic        busy,
  output logic [7:0]  dut_data_in,
  output logic        dut_a_b,
  output logic        dut_load,
  output logic        dut_in_out,
  output logic [1:0]  dut_mode_in,
  output logic        dut_mode_out,
  input  logic [15:0] dut_data_out
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, READ_HI, READ_LO, DONE} state_t;
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  state_t state;
  logic [31:0] a, b;
  logic [1:0] idx, nidx;
  logic [3:0] cnt;
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[8*(3-int'(i)) +: 8];
  endfunction
  assign nidx = idx + 2'd1;
  assign op_ready = state == IDLE;
  assign busy = state != IDLE;
  // Sequencer: all wrapper-side outputs are registered and set up one edge ahead of their cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      idx <= '0;
      cnt <= '0;
      res_valid <= 1'b0;
      res_product <= '0;
      dut_data_in <= '0;
      dut_a_b <= 1'b0;
      dut_load <= 1'b0;
      dut_in_out <= 1'b0;
      dut_mode_in <= '0;
      dut_mode_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          a <= op_a;
          b <= op_b;
          idx <= '0;
          state <= LOAD_A;
          dut_load <= 1'b1;
          dut_a_b <= 1'b1;
          dut_mode_in <= '0;
          dut_data_in <= byte_of(op_a, 2'd0);
        end
        LOAD_A: begin
          idx <= nidx;
          dut_mode_in <= nidx;
          dut_a_b <= idx != 2'd3;
          dut_data_in <= idx == 2'd3 ? byte_of(b, 2'd0) : byte_of(a, nidx);
          if (idx == 2'd3) state <= LOAD_B;
        end
        LOAD_B: if (idx == 2'd3) begin
          idx <= '0;
          cnt <= '0;
          state <= READ_HI;
          dut_load <= 1'b0;
          dut_in_out <= 1'b1;
          dut_mode_out <= 1'b1;
          dut_mode_in <= '0;
          dut_data_in <= '0;
        end else begin
          idx <= nidx;
          dut_mode_in <= nidx;
          dut_data_in <= byte_of(b, nidx);
        end
        READ_HI: if (cnt == SETTLE) begin
          res_product[31:16] <= dut_data_out;
          cnt <= '0;
          state <= READ_LO;
          dut_mode_out <= 1'b0;
        end else cnt <= cnt + 4'd1;
        READ_LO: if (cnt == SETTLE) begin
          res_product[15:0] <= dut_data_out;
          cnt <= '0;
          state <= DONE;
          res_valid <= 1'b1;
          dut_in_out <= 1'b0;
        end else cnt <= cnt + 4'd1;
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
